// File: rtl/mul_seq_ctl_if.sv
// Handshake and control bundle for the mul_seq_ctl multiply sequencer.
// The master drives requests and operand zero flags; the slave drives datapath controls.
interface mul_seq_ctl_if;
   logic       start;
   logic       flush;
   logic [3:0] a_byte_zero;
   logic [3:0] b_byte_zero;
   logic [1:0] ma_sel;
   logic [1:0] mb_sel;
   logic [4:0] shift_val;
   logic       upd_reg;
   logic       clr_reg;
   logic       busy;
   logic       done;

   modport master (
      output start, flush, a_byte_zero, b_byte_zero,
      input  ma_sel, mb_sel, shift_val, upd_reg, clr_reg, busy, done
   );

   modport slave (
      input  start, flush, a_byte_zero, b_byte_zero,
      output ma_sel, mb_sel, shift_val, upd_reg, clr_reg, busy, done
   );
endinterface

// File: rtl/mul_seq_ctl.sv
// Sequencer for a 32-bit low-word multiply built from 8x8 byte partial products (i+j<=3).
// Optional zero skipping of inactive byte pairs is enabled by defining MUL_ZERO_SKIP_EN.
module mul_seq_ctl (
   input  logic         clk,
   input  logic         rst,
   mul_seq_ctl_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CLR  = 2'd1;
   localparam logic [1:0] STEP = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   localparam logic [3:0] LAST_STEP = 4'd9;

   logic [1:0] state, state_nxt;
   logic [3:0] idx, idx_nxt;
   logic [1:0] step_i, step_j, pos_sum;
   logic       found_clr, found_step;
   logic [3:0] next_clr, next_step;

   // Step index -> {i, j} byte pair, in table order
   function automatic logic [3:0] pair_of(input logic [3:0] k);
      case (k)
         4'd0:    return {2'd0, 2'd0};
         4'd1:    return {2'd0, 2'd1};
         4'd2:    return {2'd0, 2'd2};
         4'd3:    return {2'd0, 2'd3};
         4'd4:    return {2'd1, 2'd0};
         4'd5:    return {2'd1, 2'd1};
         4'd6:    return {2'd1, 2'd2};
         4'd7:    return {2'd2, 2'd0};
         4'd8:    return {2'd2, 2'd1};
         4'd9:    return {2'd3, 2'd0};
         default: return {2'd0, 2'd0};
      endcase
   endfunction

`ifdef MUL_ZERO_SKIP_EN
   // {found, index} of the first active step at or after 'from'
   function automatic logic [4:0] next_active(input logic [3:0] from,
                                              input logic [3:0] az,
                                              input logic [3:0] bz);
      logic [4:0] r;
      logic [3:0] p;
      logic [3:0] kk;
      r = '0;
      for (int unsigned k = 0; k < 10; k++) begin
         kk = 4'(k);
         p  = pair_of(kk);
         if (!r[4] && (kk >= from) && !(az[p[3:2]] | bz[p[1:0]]))
            r = {1'b1, kk};
      end
      return r;
   endfunction

   assign {found_clr, next_clr}   = next_active(4'd0, bus.a_byte_zero, bus.b_byte_zero);
   assign {found_step, next_step} = next_active(idx + 4'd1, bus.a_byte_zero, bus.b_byte_zero);
`else
   logic unused_zero_flags;
   assign unused_zero_flags = ^{bus.a_byte_zero, bus.b_byte_zero};
   assign found_clr  = 1'b1;
   assign next_clr   = 4'd0;
   assign found_step = (idx < LAST_STEP);
   assign next_step  = idx + 4'd1;
`endif

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            idx_nxt = '0;
            if (bus.start && !bus.flush) state_nxt = CLR;
         end
         CLR: begin
            if (bus.flush) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else if (found_clr) begin
               state_nxt = STEP;
               idx_nxt   = next_clr;
            end else begin
               state_nxt = DONE;
               idx_nxt   = '0;
            end
         end
         STEP: begin
            if (bus.flush) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else if (found_step) begin
               idx_nxt   = next_step;
            end else begin
               state_nxt = DONE;
               idx_nxt   = '0;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   assign {step_i, step_j} = pair_of(idx);
   assign pos_sum          = step_i + step_j;

   always_comb begin
      bus.ma_sel    = '0;
      bus.mb_sel    = '0;
      bus.shift_val = '0;
      bus.upd_reg   = 1'b0;
      bus.clr_reg   = 1'b0;
      bus.done      = 1'b0;
      bus.busy      = (state != IDLE);
      case (state)
         CLR:  bus.clr_reg = 1'b1;
         STEP: begin
            bus.upd_reg   = 1'b1;
            bus.ma_sel    = step_i;
            bus.mb_sel    = step_j;
            bus.shift_val = {pos_sum, 3'b000};
         end
         DONE: bus.done = 1'b1;
         default: ;
      endcase
   end
endmodule
